// File: rtl/fft_tw_sched_pkg.sv
// fft_tw_sched_pkg: shared FFT scheduler types, size limits and twiddle ROM geometry.
package fft_tw_sched_pkg;
    localparam int MAX_LOG2N_DEF = 10;
    localparam int MIN_LOG2N     = 3;
    localparam int TW_W          = 10;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, FIN} state_t;

    function automatic logic log2n_legal(input logic [3:0] n, input int max_log2n);
        return (n >= 4'(MIN_LOG2N)) && (n <= 4'(max_log2n));
    endfunction
endpackage

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: maps butterfly counter k and stage s to in-place operand addresses and twiddle index.
module fft_bf_addr_gen
    import fft_tw_sched_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-2:0]   i_k,
    input  logic [3:0]      i_s,
    output logic [AW-1:0]   o_addr_a,
    output logic [AW-1:0]   o_addr_b,
    output logic [TW_W-1:0] o_tw_idx
);
    logic [AW-1:0] w_k;
    logic [AW-1:0] w_h;
    logic [AW-1:0] w_j;

    assign w_k      = {1'b0, i_k};
    assign w_h      = AW'(1) << i_s;
    assign w_j      = w_k & (w_h - AW'(1));
    // group index g=k>>s lands at g*2h, the in-group offset j fills the low bits
    assign o_addr_a = ((w_k >> i_s) << (i_s + 4'd1)) | w_j;
    assign o_addr_b = o_addr_a | w_h;
    assign o_tw_idx = TW_W'(w_j) << (4'(TW_W - 1) - i_s);
endmodule

// File: rtl/fft_tw_sched.sv
// fft_tw_sched: radix-2 in-place FFT butterfly/twiddle scheduler with stage handshaking.
module fft_tw_sched
    import fft_tw_sched_pkg::*;
#(
    parameter int MAX_LOG2N = MAX_LOG2N_DEF,
    parameter int AW        = MAX_LOG2N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [3:0]      i_log2n,
    input  logic            i_abort,
    input  logic            i_stage_ack,
    input  logic            i_bf_ready,
    output logic            o_bf_valid,
    output logic [AW-1:0]   o_addr_a,
    output logic [AW-1:0]   o_addr_b,
    output logic [TW_W-1:0] o_tw_idx,
    output logic [3:0]      o_stage,
    output logic            o_last_bf,
    output logic            o_busy,
    output logic            o_done
);
    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_l;
    logic [3:0]    r_s;
    logic [AW-2:0] r_k;
    logic          r_done;
    logic [AW-2:0] w_kmax;
    logic          w_last;
    logic          w_hs;
    logic          w_accept;
    logic [AW-1:0] w_a;
    logic [AW-1:0] w_b;
    logic [TW_W-1:0] w_tw;

    fft_bf_addr_gen #(.AW(AW)) u_addr (
        .i_k      (r_k),
        .i_s      (r_s),
        .o_addr_a (w_a),
        .o_addr_b (w_b),
        .o_tw_idx (w_tw)
    );

    assign w_kmax   = {(AW-1){1'b1}} >> (4'(AW) - r_l);
    assign w_last   = r_k == w_kmax;
    assign w_hs     = o_bf_valid & i_bf_ready;
    assign w_accept = (r_state == IDLE) & i_start & log2n_legal(i_log2n, MAX_LOG2N);

    always_comb begin
        w_next = r_state;
        if (r_state != IDLE && i_abort)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = w_accept ? RUN : IDLE;
                RUN:     w_next = (w_hs && w_last) ? ((r_s == r_l - 4'd1) ? FIN : WAIT) : RUN;
                WAIT:    w_next = i_stage_ack ? RUN : WAIT;
                FIN:     w_next = i_stage_ack ? IDLE : FIN;
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_l     <= '0;
            r_s     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_l     <= w_accept ? i_log2n : r_l;
            r_k     <= (r_state == RUN && w_next == RUN) ? r_k + (AW-1)'(w_hs) : '0;
            r_s     <= (r_state == WAIT && w_next == RUN) ? r_s + 4'd1 :
                       (w_next == IDLE) ? '0 : r_s;
            r_done  <= (r_state == FIN) & i_stage_ack & ~i_abort;
        end
    end

    assign o_bf_valid = r_state == RUN;
    assign o_busy     = r_state != IDLE;
    assign o_done     = r_done;
    assign o_stage    = r_s;
    assign o_last_bf  = o_bf_valid & w_last;
    assign o_addr_a   = o_bf_valid ? w_a : '0;
    assign o_addr_b   = o_bf_valid ? w_b : '0;
    assign o_tw_idx   = o_bf_valid ? w_tw : '0;
endmodule

// File: tb/tb_fft_tw_sched.sv
// tb_fft_tw_sched: directed bench with a queue-based butterfly schedule model checked every cycle.
module tb_fft_tw_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] log2n = '0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;
    logic       ready = 1'b0;
    logic       o_bf_valid, o_last_bf, o_busy, o_done;
    logic [9:0] o_addr_a, o_addr_b, o_tw_idx;
    logic [3:0] o_stage;

    typedef struct {int s; int a; int b; int tw; bit last;} cmd_t;
    cmd_t exp_q[$];
    cmd_t log_q[$];
    int errors = 0, checks = 0;
    int mst = 0, mi = 0, ms = 0, ml = 0;
    bit mdone = 0;
    bit auto_ack = 0, rnd_ready = 0;
    int wcnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    fft_tw_sched dut (
        .clk(clk), .rst(rst), .i_start(start), .i_log2n(log2n), .i_abort(abort),
        .i_stage_ack(ack), .i_bf_ready(ready), .o_bf_valid(o_bf_valid),
        .o_addr_a(o_addr_a), .o_addr_b(o_addr_b), .o_tw_idx(o_tw_idx),
        .o_stage(o_stage), .o_last_bf(o_last_bf), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // whole transform as an ordered list: per stage, blocks of 2h points, j walks each block
    task automatic build(input int l);
        cmd_t c;
        exp_q.delete();
        for (int s = 0; s < l; s++) begin
            int h = 1 << s;
            for (int b = 0; b < (1 << l); b += 2 * h)
                for (int j = 0; j < h; j++) begin
                    c.s = s; c.a = b + j; c.b = b + j + h; c.tw = j * (512 >> s);
                    c.last = (b == (1 << l) - 2 * h) && (j == h - 1);
                    exp_q.push_back(c);
                end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mst = 0; mi = 0; ms = 0; mdone = 0;
        end else begin
            mdone = 0;
            if (mst != 0 && abort) begin
                mst = 0; ms = 0;
            end else if (mst == 0) begin
                if (start && log2n >= 3 && log2n <= 10) begin
                    ml = int'(log2n); build(ml); mi = 0; ms = 0; mst = 1;
                end
            end else if (mst == 1) begin
                if (ready && mi < exp_q.size()) begin
                    if (exp_q[mi].last) mst = (exp_q[mi].s == ml - 1) ? 3 : 2;
                    mi++;
                end
            end else if (ack) begin
                if (mst == 2) begin ms++; mst = 1; end
                else begin mdone = 1; mst = 0; ms = 0; end
            end
        end
    end

    always @(negedge clk) begin
        cmd_t c;
        chk("busy", 32'(o_busy), 32'(mst != 0));
        chk("bf_valid", 32'(o_bf_valid), 32'(mst == 1));
        chk("done", 32'(o_done), 32'(mdone));
        if (mst != 0) chk("stage", 32'(o_stage), 32'(ms));
        if (mst == 1 && mi < exp_q.size()) begin
            chk("addr_a", 32'(o_addr_a), 32'(exp_q[mi].a));
            chk("addr_b", 32'(o_addr_b), 32'(exp_q[mi].b));
            chk("tw_idx", 32'(o_tw_idx), 32'(exp_q[mi].tw));
            chk("last_bf", 32'(o_last_bf), 32'(exp_q[mi].last));
        end
        if (o_bf_valid && ready) begin
            c.s = int'(o_stage); c.a = int'(o_addr_a); c.b = int'(o_addr_b);
            c.tw = int'(o_tw_idx); c.last = o_last_bf;
            log_q.push_back(c);
        end
        if (o_done) done_cnt++;
    end

    always @(posedge clk) begin
        #2;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
        if (auto_ack) begin
            wcnt = (o_busy && !o_bf_valid) ? wcnt + 1 : 0;
            ack = (wcnt == 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic all_zero(input string name);
        chk({name, "_valid"}, 32'(o_bf_valid), 0);
        chk({name, "_a"}, 32'(o_addr_a), 0);
        chk({name, "_b"}, 32'(o_addr_b), 0);
        chk({name, "_tw"}, 32'(o_tw_idx), 0);
        chk({name, "_stage"}, 32'(o_stage), 0);
        chk({name, "_last"}, 32'(o_last_bf), 0);
        chk({name, "_busy"}, 32'(o_busy), 0);
        chk({name, "_done"}, 32'(o_done), 0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        tick();
        chk("done_pulses", 32'(done_cnt), 1);
    endtask

    task automatic run(input int l, input int budget);
        log_q.delete();
        done_cnt = 0;
        log2n = 4'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(budget);
    endtask

    initial begin
        tick();
        tick();
        all_zero("reset");
        rst = 1'b0;
        ready = 1'b1;
        auto_ack = 1'b1;
        tick();

        run(3, 200);
        chk("n8_handshakes", 32'(log_q.size()), 12);
        if (log_q.size() >= 12) begin
            for (int i = 0; i < 4; i++) begin
                chk("n8_s0_a", 32'(log_q[i].a), 32'(2 * i));
                chk("n8_s0_b", 32'(log_q[i].b), 32'(2 * i + 1));
                chk("n8_s0_tw", 32'(log_q[i].tw), 0);
                chk("n8_s2_tw", 32'(log_q[8 + i].tw), 32'(128 * i));
                chk("n8_s2_stage", 32'(log_q[8 + i].s), 2);
            end
        end

        foreach (log_q[i]) if (0) ;
        log2n = 4'd2; start = 1'b1; tick(); start = 1'b0; tick();
        chk("log2n2_busy", 32'(o_busy), 0);
        log2n = 4'd11; start = 1'b1; tick(); start = 1'b0; tick();
        chk("log2n11_busy", 32'(o_busy), 0);

        log_q.delete();
        done_cnt = 0;
        log2n = 4'd3; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        log2n = 4'd4; start = 1'b1; tick(); start = 1'b0;
        wait_done(200);
        chk("busy_start_handshakes", 32'(log_q.size()), 12);

        rnd_ready = 1'b1;
        run(5, 2000);
        rnd_ready = 1'b0;
        ready = 1'b1;
        chk("n32_handshakes", 32'(log_q.size()), 80);
        if (log_q.size() >= 80) begin
            chk("n32_last_a", 32'(log_q[79].a), 15);
            chk("n32_last_b", 32'(log_q[79].b), 31);
            chk("n32_last_tw", 32'(log_q[79].tw), 480);
        end

        done_cnt = 0;
        log2n = 4'd3; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 50 && !(o_bf_valid && o_last_bf); i++) tick();
        chk("abort_reach_last", 32'(o_last_bf), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 0);
        tick(); tick(); tick();
        chk("abort_no_done", 32'(done_cnt), 0);
        run(3, 200);
        chk("after_abort_handshakes", 32'(log_q.size()), 12);
        if (log_q.size() >= 1) begin
            chk("after_abort_s", 32'(log_q[0].s), 0);
            chk("after_abort_b", 32'(log_q[0].b), 1);
        end

        run(10, 8000);
        chk("n1024_handshakes", 32'(log_q.size()), 5120);
        if (log_q.size() >= 5120) begin
            chk("n1024_s", 32'(log_q[5119].s), 9);
            chk("n1024_a", 32'(log_q[5119].a), 511);
            chk("n1024_b", 32'(log_q[5119].b), 1023);
            chk("n1024_tw", 32'(log_q[5119].tw), 511);
            chk("n1024_last", 32'(log_q[5119].last), 1);
        end

        done_cnt = 0;
        log2n = 4'd4; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 100 && !(o_busy && o_stage == 4'd1); i++) tick();
        chk("reach_stage1", 32'(o_stage), 1);
        rst = 1'b1;
        tick();
        all_zero("midrst");
        rst = 1'b0;
        auto_ack = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(); tick();
        chk("idle_ack_busy", 32'(o_busy), 0);
        chk("idle_ack_no_done", 32'(done_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
